// File: rtl/shift_add_mult_ctrl.sv
// Control FSM for the shift-add two's-complement multiplier.
// Walks WIDTH bits with a counter; subtracts on the sign bit.
module shift_add_mult_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             ClearA_LoadB,
  input  logic             M,
  output logic             Clr_Ld,
  output logic             Clear_XA,
  output logic             Add_En,
  output logic             Sub_En,
  output logic             Shift_En,
  output logic             Busy,
  output logic             Done,
  output logic [CNT_W-1:0] Count
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ADD,
    SHIFT,
    HOLD
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             last;

  assign last  = (count_q == LAST);
  assign Count = count_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    Clr_Ld   = 1'b0;
    Clear_XA = 1'b0;
    Add_En   = 1'b0;
    Sub_En   = 1'b0;
    Shift_En = 1'b0;
    Busy     = 1'b0;
    Done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        Clr_Ld  = ClearA_LoadB;
        count_d = '0;
        if (Run) state_d = CLEAR;
      end
      CLEAR: begin
        Clear_XA = 1'b1;
        Busy     = 1'b1;
        count_d  = '0;
        state_d  = ADD;
      end
      ADD: begin
        Busy = 1'b1;
        // the sign bit of the multiplier carries negative weight
        if (M) begin
          Sub_En = last;
          Add_En = !last;
        end
        state_d = SHIFT;
      end
      SHIFT: begin
        Shift_En = 1'b1;
        Busy     = 1'b1;
        if (last) begin
          state_d = HOLD;
        end else begin
          count_d = count_q + 1'b1;
          state_d = ADD;
        end
      end
      HOLD: begin
        Done = 1'b1;
        if (!Run) begin
          state_d = IDLE;
          count_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Scoreboard bench for shift_add_mult_ctrl.
// Runs WIDTH=8 and WIDTH=4 instances with directed stimulus.
module tb_shift_add_mult_ctrl;

  typedef struct packed {
    logic [7:0] clears;
    logic [7:0] adds;
    logic [7:0] subs;
    logic [7:0] shifts;
    logic [7:0] busy;
    logic [7:0] add_mask;
    logic [7:0] sub_mask;
    logic [7:0] clr_busy;
  } rec_t;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic run8 = 1'b0, cl8 = 1'b0, m8 = 1'b0;
  logic run4 = 1'b0, cl4 = 1'b0, m4;
  logic [3:0] pat4 = 4'b1101;

  logic ld8, cx8, ad8, sb8, sh8, bz8, dn8;
  logic [2:0] c8;
  logic ld4, cx4, ad4, sb4, sh4, bz4, dn4;
  logic [1:0] c4;

  int n_cmp = 0;
  int n_bad = 0;
  rec_t q8[$];
  rec_t q4[$];
  rec_t a8 = '0, a4 = '0;
  logic dn8_q = 1'b0, sh8_q = 1'b0;
  logic dn4_q = 1'b0, sh4_q = 1'b0;

  always #5 Clk = ~Clk;

  assign m4 = pat4[c4];

  shift_add_mult_ctrl #(.WIDTH(8)) u8 (
    .Clk(Clk), .Reset(Reset), .Run(run8),
    .ClearA_LoadB(cl8), .M(m8),
    .Clr_Ld(ld8), .Clear_XA(cx8),
    .Add_En(ad8), .Sub_En(sb8),
    .Shift_En(sh8), .Busy(bz8),
    .Done(dn8), .Count(c8)
  );

  shift_add_mult_ctrl #(.WIDTH(4)) u4 (
    .Clk(Clk), .Reset(Reset), .Run(run4),
    .ClearA_LoadB(cl4), .M(m4),
    .Clr_Ld(ld4), .Clear_XA(cx4),
    .Add_En(ad4), .Sub_En(sb4),
    .Shift_En(sh4), .Busy(bz4),
    .Done(dn4), .Count(c4)
  );

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h",
               name, got, exp);
    end
  endtask

  function automatic rec_t mk(input int cl, ad, sb, sh,
                              input int bz, am, sm);
    rec_t r;
    r.clears   = 8'(cl);
    r.adds     = 8'(ad);
    r.subs     = 8'(sb);
    r.shifts   = 8'(sh);
    r.busy     = 8'(bz);
    r.add_mask = 8'(am);
    r.sub_mask = 8'(sm);
    r.clr_busy = 8'd0;
    return r;
  endfunction

  task automatic cmp_run(input string n, input rec_t g,
                         input rec_t e);
    check({n, ".clear_xa"}, 32'(g.clears), 32'(e.clears));
    check({n, ".add_en"}, 32'(g.adds), 32'(e.adds));
    check({n, ".sub_en"}, 32'(g.subs), 32'(e.subs));
    check({n, ".shift_en"}, 32'(g.shifts), 32'(e.shifts));
    check({n, ".busy_cyc"}, 32'(g.busy), 32'(e.busy));
    check({n, ".add_cnt"}, 32'(g.add_mask), 32'(e.add_mask));
    check({n, ".sub_cnt"}, 32'(g.sub_mask), 32'(e.sub_mask));
    check({n, ".clr_ld_busy"}, 32'(g.clr_busy), 32'(e.clr_busy));
  endtask

  always @(negedge Clk) begin
    if (Reset) begin
      a8 = '0;
    end else begin
      if (bz8) begin
        a8.busy   = a8.busy + 8'd1;
        a8.clears = a8.clears + 8'(cx8);
        a8.adds   = a8.adds + 8'(ad8);
        a8.subs   = a8.subs + 8'(sb8);
        a8.shifts = a8.shifts + 8'(sh8);
        a8.clr_busy = a8.clr_busy + 8'(ld8);
        if (ad8) a8.add_mask = a8.add_mask | (8'd1 << c8);
        if (sb8) a8.sub_mask = a8.sub_mask | (8'd1 << c8);
      end
      if (ad8 && sb8) check("add_sub_excl8", 1, 0);
      if (dn8 && !dn8_q) begin
        check("done_after_shift8", 32'(sh8_q), 1);
        if (q8.size() == 0) check("q8_underflow", 1, 0);
        else cmp_run("run8", a8, q8.pop_front());
        a8 = '0;
      end
    end
    dn8_q = dn8;
    sh8_q = sh8;
  end

  always @(negedge Clk) begin
    if (Reset) begin
      a4 = '0;
    end else begin
      if (bz4) begin
        a4.busy   = a4.busy + 8'd1;
        a4.clears = a4.clears + 8'(cx4);
        a4.adds   = a4.adds + 8'(ad4);
        a4.subs   = a4.subs + 8'(sb4);
        a4.shifts = a4.shifts + 8'(sh4);
        a4.clr_busy = a4.clr_busy + 8'(ld4);
        if (ad4) a4.add_mask = a4.add_mask | (8'd1 << c4);
        if (sb4) a4.sub_mask = a4.sub_mask | (8'd1 << c4);
      end
      if (ad4 && sb4) check("add_sub_excl4", 1, 0);
      if (dn4 && !dn4_q) begin
        check("done_after_shift4", 32'(sh4_q), 1);
        if (q4.size() == 0) check("q4_underflow", 1, 0);
        else cmp_run("run4", a4, q4.pop_front());
        a4 = '0;
      end
    end
    dn4_q = dn4;
    sh4_q = sh4;
  end

  task automatic wait_done8(input int lim);
    int n = 0;
    while (!dn8 && n < lim) begin
      @(negedge Clk);
      n++;
    end
    if (!dn8) check("timeout8", 0, 1);
  endtask

  task automatic wait_done4(input int lim);
    int n = 0;
    while (!dn4 && n < lim) begin
      @(negedge Clk);
      n++;
    end
    if (!dn4) check("timeout4", 0, 1);
  endtask

  function automatic logic [31:0] outs8();
    return 32'({ld8, cx8, ad8, sb8, sh8, bz8, dn8, c8});
  endfunction

  function automatic logic [31:0] outs4();
    return 32'({ld4, cx4, ad4, sb4, sh4, bz4, dn4, c4});
  endfunction

  initial begin
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    check("reset_outs8", outs8(), 0);
    check("reset_outs4", outs4(), 0);

    @(posedge Clk); #1 cl8 = 1'b1;
    @(negedge Clk);
    check("clr_ld_idle", 32'(ld8), 1);
    check("clr_ld_no_busy", 32'(bz8), 0);
    @(posedge Clk); #1 cl8 = 1'b0;
    @(negedge Clk);
    check("idle_stays", outs8(), 0);

    // M=1, Run pulse, ClearA_LoadB held through the run
    @(posedge Clk); #1;
    q8.push_back(mk(1, 7, 1, 8, 17, 8'h7F, 8'h80));
    m8 = 1'b1; run8 = 1'b1; cl8 = 1'b1;
    @(negedge Clk);
    check("clr_ld_with_run", 32'(ld8), 1);
    @(posedge Clk); #1 run8 = 1'b0;
    @(negedge Clk);
    check("clear_state", 32'({cx8, bz8, ld8}), 32'b110);
    wait_done8(40);
    cl8 = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    check("idle_after_run1", outs8(), 0);

    // M=0, Run held through HOLD
    @(posedge Clk); #1;
    q8.push_back(mk(1, 0, 0, 8, 17, 0, 0));
    m8 = 1'b0; run8 = 1'b1;
    wait_done8(40);
    repeat (3) begin
      @(negedge Clk);
      check("done_held", 32'({dn8, bz8, c8}), 32'b1_0_111);
    end
    @(posedge Clk); #1 run8 = 1'b0;
    @(posedge Clk); #1;
    check("idle_after_drop", outs8(), 0);
    repeat (3) @(negedge Clk);
    check("no_second_run", 32'({bz8, dn8}), 0);

    // reset during the 5th busy cycle
    @(posedge Clk); #1 m8 = 1'b1; run8 = 1'b1;
    @(posedge Clk); #1 run8 = 1'b0;
    repeat (4) @(posedge Clk);
    #1 Reset = 1'b1;
    @(negedge Clk);
    check("busy_before_rst", 32'(bz8), 1);
    @(posedge Clk); #1 Reset = 1'b0;
    @(negedge Clk);
    check("idle_after_rst", outs8(), 0);

    @(posedge Clk); #1;
    q8.push_back(mk(1, 7, 1, 8, 17, 8'h7F, 8'h80));
    run8 = 1'b1;
    @(posedge Clk); #1 run8 = 1'b0;
    wait_done8(40);
    @(posedge Clk);
    @(negedge Clk);
    check("idle_after_run4", outs8(), 0);

    // WIDTH=4, M pattern 1,0,1,1 by bit index
    @(posedge Clk); #1;
    q4.push_back(mk(1, 2, 1, 4, 9, 8'h05, 8'h08));
    run4 = 1'b1;
    @(posedge Clk); #1 run4 = 1'b0;
    wait_done4(30);
    @(posedge Clk);
    @(negedge Clk);
    check("idle_after_w4", outs4(), 0);

    check("q8_drained", 32'(q8.size()), 0);
    check("q4_drained", 32'(q4.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
